ov5640_sccb_slave: RTL and testbench
====================================

OV5640_SCCB_SLAVE -- requirements
Module: ov5640_sccb_slave

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h3C, 7-bit SCCB device address answered.
REQ-002 SHALL have parameter AW, default 8, register-file index width (2^AW bytes).
REQ-003 SHALL have parameter FILT_LEN, default 4, clk cycles an SCL/SDA level must hold before it is accepted.
REQ-004 SHALL have port clk  input  1  system clock; sole clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port scl_i  input  1  SCCB clock from the bus master (asynchronous).
REQ-007 SHALL have port sda_i  input  1  SCCB data from the bus (asynchronous).
REQ-008 SHALL have port sda_o  output  1  data driven onto the bus; constant 0.
REQ-009 SHALL have port sda_t  output  1  tristate enable; 1 releases SDA, 0 pulls it low.
REQ-010 SHALL have port wr_valid  output  1  one-cycle strobe per accepted register write.
REQ-011 SHALL have port wr_addr  output  16  register address of the write.
REQ-012 SHALL have port wr_data  output  8  data byte of the write.
REQ-013 SHALL have port busy  output  1  high from START to STOP while addressed.

Function
REQ-014 SHALL pass scl_i/sda_i through a 2-FF synchronizer, then a FILT_LEN-cycle stability filter; all edges below refer to filtered signals.
REQ-015 SHALL detect START/repeated START as SDA falling while SCL high, and STOP as SDA rising while SCL high; either SHALL override the current state immediately.
REQ-016 SHALL sample SDA on SCL rising edges and change sda_t only on SCL falling edges.
REQ-017 SHALL implement states IDLE, DEV, DEV_ACK, RH, RH_ACK, RL, RL_ACK, WR, WR_ACK, RD, RD_ACK.
REQ-018 START -> DEV; after 8 bits, if [7:1]==DEV_ADDR -> DEV_ACK, else IDLE with SDA released until the next START.
REQ-019 DEV_ACK with R/W=0 -> RH -> RH_ACK -> RL -> RL_ACK -> WR; R/W=1 -> RD using the current address pointer.
REQ-020 In each *_ACK state, sda_t SHALL be 0 from the SCL falling edge after bit 8 until the next SCL falling edge.
REQ-021 WR: each received byte SHALL write mem[ptr[AW-1:0]], pulse wr_valid with wr_addr=ptr on the cycle the ACK drive begins, then ptr SHALL increment (16-bit wrap 0xFFFF->0x0000).
REQ-022 RD: the byte SHALL be fetched at ACK time and the MSB driven on the SCL falling edge that ends the ACK; a '0' bit SHALL set sda_t=0 and a '1' bit sda_t=1.
REQ-023 RD_ACK: master ACK (SDA=0) -> increment ptr, reload, RD; master NACK -> release SDA, IDLE.
REQ-024 Address bits above AW SHALL be ignored for storage (aliasing) but reported in full on wr_addr.
REQ-025 START during a byte SHALL discard that partial byte without writing or pulsing wr_valid.
REQ-026 ptr SHALL persist across STOP so that a write of only RH/RL followed by a read transaction returns that address.

Reset
REQ-027 On rst: state IDLE, sda_t=1, wr_valid=0, wr_addr=0, wr_data=0, busy=0, ptr=0, filters loaded with 1; mem contents SHALL NOT be cleared.
REQ-028 Reset mid-transfer SHALL release SDA on the next clk edge.

Configuration
REQ-029 With OV5640_SLV_CHIPID_EN defined, reads of 0x300A/0x300B SHALL return 8'h56/8'h40, and writes to them SHALL be ACKed but SHALL NOT update mem or pulse wr_valid.
REQ-030 Without OV5640_SLV_CHIPID_EN, those addresses SHALL behave as ordinary memory.

Structure
REQ-031 A shared package ov5640_pkg SHALL hold the state enum, OV5640_CHIPID_H/L address and value constants, and the default DEV_ADDR.
REQ-032 Synchronizer+filter SHALL be sub-module sccb_in_filt, instantiated once per line.

Verification
REQ-033 Write 0x3C<<1|0, 0x30, 0x08, 0x82 -> four ACKs, wr_valid once with wr_addr=0x3008, wr_data=0x82.
REQ-034 Write 0x4300 with 0x30,0x31,0x32 then STOP -> three wr_valid pulses at 0x4300/0x4301/0x4302; read back from 0x4300 with ACK,ACK,NACK -> 0x30,0x31,0x32, SDA released after NACK.
REQ-035 Address 0x21 -> no ACK (SDA high at 9th SCL), no wr_valid, busy=0.
REQ-036 With OV5640_SLV_CHIPID_EN defined, read 0x300A for 2 bytes -> 0x56,0x40; write 0xFF to 0x300A -> ACK, no wr_valid, re-read gives 0x56.
REQ-037 1-cycle glitch on SCL while high -> ignored; repeated START after bit 4 of a data byte -> no write, DEV entered.
REQ-038 Assert rst while driving a read '0' bit -> sda_t=1 one clk later, state IDLE.

Source files
------------

// File: rtl/ov5640_pkg.sv
// ----------------------------------------------------------------------------
// ov5640_pkg
// Shared definitions for the OV5640 SCCB register-file slave: the protocol
// state enum, the default device address and the chip-ID addresses/values
// that are answered when OV5640_SLV_CHIPID_EN is defined.
// ----------------------------------------------------------------------------
package ov5640_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        RH,
        RH_ACK,
        RL,
        RL_ACK,
        WR,
        WR_ACK,
        RD,
        RD_ACK
    } sccb_state_e;

    localparam logic [6:0]  OV5640_DEV_ADDR      = 7'h3C;

    localparam logic [15:0] OV5640_CHIPID_H_ADDR = 16'h300A;
    localparam logic [15:0] OV5640_CHIPID_L_ADDR = 16'h300B;
    localparam logic [7:0]  OV5640_CHIPID_H_VAL  = 8'h56;
    localparam logic [7:0]  OV5640_CHIPID_L_VAL  = 8'h40;

endpackage

// File: rtl/sccb_in_filt.sv
// ----------------------------------------------------------------------------
// sccb_in_filt
// Brings one asynchronous SCCB line into the clk domain through a 2-FF
// synchronizer, then only lets a new level through once it has been seen
// for FILT_LEN consecutive clk cycles, so short glitches never reach the
// protocol logic.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset; all stages load 1 (idle bus)
//   din   in   raw asynchronous line
//   dout  out  synchronized, filtered line
// ----------------------------------------------------------------------------
module sccb_in_filt #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          out_q,   out_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        out_d   = out_q;
        cnt_d   = '0;
        // cnt counts cycles the synchronized level has disagreed with the
        // output; the output follows on the FILT_LEN-th such cycle.
        if (sync2_q != out_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
                out_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            out_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = out_q;

endmodule

// File: rtl/ov5640_sccb_slave.sv
// ----------------------------------------------------------------------------
// ov5640_sccb_slave
// SCCB (I2C-style) slave emulating the OV5640 register interface: 16-bit
// register address (high byte, low byte) followed by sequential data writes,
// or sequential reads from the current address pointer. Storage is a
// 2^AW-byte register file indexed by the low AW pointer bits.
//
// Build option: OV5640_SLV_CHIPID_EN -- when defined, 0x300A/0x300B read
// back the fixed chip ID and writes to them are ACKed but discarded.
//
// Ports:
//   clk       in   system clock (sole clock)
//   rst       in   synchronous active-high reset
//   scl_i     in   SCCB clock from the master (asynchronous)
//   sda_i     in   SCCB data line (asynchronous)
//   sda_o     out  value driven onto SDA when enabled; always 0
//   sda_t     out  1 releases SDA, 0 pulls it low
//   wr_valid  out  one-cycle strobe per accepted register write
//   wr_addr   out  full 16-bit register address of the write
//   wr_data   out  data byte of the write
//   busy      out  high from an addressed START until STOP
// ----------------------------------------------------------------------------
module ov5640_sccb_slave
    import ov5640_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = OV5640_DEV_ADDR,
    parameter int         AW       = 8,
    parameter int         FILT_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_t,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

    logic scl_f, sda_f;

    sccb_in_filt #(.FILT_LEN(FILT_LEN)) u_scl_filt (.clk(clk), .rst(rst), .din(scl_i), .dout(scl_f));
    sccb_in_filt #(.FILT_LEN(FILT_LEN)) u_sda_filt (.clk(clk), .rst(rst), .din(sda_i), .dout(sda_f));

    sccb_state_e state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  rd_sh_q, rd_sh_d;
    logic [15:0] ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        sda_t_q, sda_t_d;
    logic        busy_q, busy_d;
    logic        wr_valid_q, wr_valid_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        scl_p_q, scl_p_d;
    logic        sda_p_q, sda_p_d;

    logic [7:0]  mem [0:(1<<AW)-1];
    logic        mem_we;
    logic [15:0] ptr_inc;
    logic [AW-1:0] rd_idx;
    logic [7:0]  rd_byte;
    logic        chipid_wr_hit;

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  =  scl_f & ~scl_p_q;
    assign scl_fall  = ~scl_f &  scl_p_q;
    assign start_det =  scl_f &  scl_p_q &  sda_p_q & ~sda_f;
    assign stop_det  =  scl_f &  scl_p_q & ~sda_p_q &  sda_f;
    assign ptr_inc   = ptr_q + 16'd1;

`ifdef OV5640_SLV_CHIPID_EN
    assign chipid_wr_hit = (ptr_q == OV5640_CHIPID_H_ADDR) || (ptr_q == OV5640_CHIPID_L_ADDR);
`else
    assign chipid_wr_hit = 1'b0;
`endif

    // Read data source: RD_ACK fetches the byte after the current pointer,
    // every other fetch point uses the pointer itself.
    always_comb begin
        rd_idx  = (state_q == RD_ACK) ? ptr_inc[AW-1:0] : ptr_q[AW-1:0];
        rd_byte = mem[rd_idx];
`ifdef OV5640_SLV_CHIPID_EN
        if (((state_q == RD_ACK) ? ptr_inc : ptr_q) == OV5640_CHIPID_H_ADDR) begin
            rd_byte = OV5640_CHIPID_H_VAL;
        end else if (((state_q == RD_ACK) ? ptr_inc : ptr_q) == OV5640_CHIPID_L_ADDR) begin
            rd_byte = OV5640_CHIPID_L_VAL;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rd_sh_d    = rd_sh_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        sda_t_d    = sda_t_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        scl_p_d    = scl_f;
        sda_p_d    = sda_f;
        mem_we     = 1'b0;

        // START/STOP abort whatever byte is in flight.
        if (start_det) begin
            state_d   = DEV;
            bit_cnt_d = '0;
            sda_t_d   = 1'b1;
        end else if (stop_det) begin
            state_d = IDLE;
            sda_t_d = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                DEV, RH, RL, WR: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        // Byte complete: begin the ACK drive on this fall.
                        bit_cnt_d = '0;
                        sda_t_d   = 1'b0;
                        case (state_q)
                            DEV: begin
                                if (shreg_q[7:1] == DEV_ADDR) begin
                                    state_d = DEV_ACK;
                                    rw_d    = shreg_q[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = IDLE;
                                    sda_t_d = 1'b1;
                                    busy_d  = 1'b0;
                                end
                            end
                            RH: begin
                                ptr_d[15:8] = shreg_q;
                                state_d     = RH_ACK;
                            end
                            RL: begin
                                ptr_d[7:0] = shreg_q;
                                state_d    = RL_ACK;
                            end
                            default: begin
                                state_d = WR_ACK;
                                ptr_d   = ptr_inc;
                                if (!chipid_wr_hit) begin
                                    mem_we     = 1'b1;
                                    wr_valid_d = 1'b1;
                                    wr_addr_d  = ptr_q;
                                    wr_data_d  = shreg_q;
                                end
                            end
                        endcase
                    end
                end
                DEV_ACK, RH_ACK, RL_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        sda_t_d   = 1'b1;
                        case (state_q)
                            DEV_ACK: begin
                                if (rw_q) begin
                                    state_d = RD;
                                    sda_t_d = rd_byte[7];
                                    rd_sh_d = {rd_byte[6:0], 1'b0};
                                end else begin
                                    state_d = RH;
                                end
                            end
                            RH_ACK:  state_d = RL;
                            default: state_d = WR;
                        endcase
                    end
                end
                RD: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_t_d   = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = RD_ACK;
                        end else begin
                            sda_t_d = rd_sh_q[7];
                            rd_sh_d = {rd_sh_q[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    // NACK ends the read; surviving to the fall means ACK.
                    if (scl_rise && sda_f) begin
                        state_d = IDLE;
                    end else if (scl_fall) begin
                        ptr_d     = ptr_inc;
                        sda_t_d   = rd_byte[7];
                        rd_sh_d   = {rd_byte[6:0], 1'b0};
                        bit_cnt_d = '0;
                        state_d   = RD;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            rd_sh_q    <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            sda_t_q    <= 1'b1;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            rd_sh_q    <= rd_sh_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            sda_t_q    <= sda_t_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            scl_p_q    <= scl_p_d;
            sda_p_q    <= sda_p_d;
        end
    end

    // NOTE: the register file has no reset; its contents survive rst and
    // leaving it out keeps it mappable onto plain RAM/flops without a clear.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[ptr_q[AW-1:0]] <= shreg_q;
        end
    end

    assign sda_o    = 1'b0;
    assign sda_t    = sda_t_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ov5640_sccb_slave.sv
// ----------------------------------------------------------------------------
// tb_ov5640_sccb_slave
// Directed bench: a bit-banged SCCB master drives the slave through an
// open-drain bus model. A table of write/readback records covers the basic
// register traffic; hand-written sequences cover multi-byte bursts, chip ID,
// glitch rejection, repeated START mid-byte, reset mid-read and pointer wrap.
// ----------------------------------------------------------------------------
module tb_ov5640_sccb_slave;
    import ov5640_pkg::*;

    localparam int Q = 10;  // clk cycles per quarter SCL period

`ifdef OV5640_SLV_CHIPID_EN
    localparam bit CHIP = 1'b1;
`else
    localparam bit CHIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        scl_m, sda_m;
    logic        sda_line;
    logic        sda_o, sda_t, wr_valid, busy;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] log_addr [$];
    logic [7:0]  log_data [$];

    always #5 clk = ~clk;

    // Open-drain bus: the master and the slave can each only pull low.
    assign sda_line = sda_m & (sda_t ? 1'b1 : sda_o);

    ov5640_sccb_slave dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
        .sda_o    (sda_o),
        .sda_t    (sda_t),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (wr_valid) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait();
    endtask

    task automatic write_bit(input logic b, input logic glitch);
        sda_m = b; qwait();
        scl_m = 1'b1; qwait();
        if (glitch) begin
            scl_m = 1'b0;
            @(negedge clk);
            scl_m = 1'b1;
        end
        qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        b = sda_line;
        qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack, input int glitch_bit = -1);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack, 1'b0);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, output logic ack);
        logic k;
        bus_start();
        write_byte(8'h78, k);
        write_byte(a[15:8], k);
        write_byte(a[7:0], k);
        write_byte(d, ack);
        bus_stop();
    endtask

    // Leaves the slave in RD with the first data bit on the bus.
    task automatic point_read(input logic [15:0] a);
        logic k;
        bus_start();
        write_byte(8'h78, k);
        write_byte(a[15:8], k);
        write_byte(a[7:0], k);
        bus_start();
        write_byte(8'h79, k);
    endtask

    typedef struct packed {
        logic [6:0]  dev;
        logic [15:0] waddr;
        logic [7:0]  wdata;
        logic        exp_ack;
        logic        exp_wv;
        logic [15:0] raddr;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic       ack, k;
        logic [7:0] d, d1, d2;

        vecs[0] = '{7'h3C, 16'h3008, 8'h82, 1'b1, 1'b1,  16'h3008, 8'h82};
        vecs[1] = '{7'h3C, 16'h0000, 8'h5A, 1'b1, 1'b1,  16'h0000, 8'h5A};
        vecs[2] = '{7'h3C, 16'hFFFF, 8'hA5, 1'b1, 1'b1,  16'h00FF, 8'hA5};
        vecs[3] = '{7'h3C, 16'h1234, 8'h3C, 1'b1, 1'b1,  16'h1234, 8'h3C};
        vecs[4] = '{7'h21, 16'h0000, 8'h99, 1'b0, 1'b0,  16'h0000, 8'h5A};
        vecs[5] = '{7'h3C, 16'h0155, 8'hC3, 1'b1, 1'b1,  16'h0055, 8'hC3};
        vecs[6] = '{7'h3C, 16'h300A, 8'h11, 1'b1, ~CHIP, 16'h300A, CHIP ? 8'h56 : 8'h11};

        rst   = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_sda_t",    sda_t,    1'b1);
        check("rst_sda_o",    sda_o,    1'b0);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_addr",  wr_addr,  16'h0);
        check("rst_wr_data",  wr_data,  8'h0);
        check("rst_busy",     busy,     1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Table: write one register, then read it back in a new transaction.
        for (int v = 0; v < 7; v++) begin
            clear_log();
            bus_start();
            write_byte({vecs[v].dev, 1'b0}, ack);
            check($sformatf("v%0d_dev_ack", v), ack, vecs[v].exp_ack);
            check($sformatf("v%0d_busy", v), busy, vecs[v].exp_ack);
            write_byte(vecs[v].waddr[15:8], k);
            write_byte(vecs[v].waddr[7:0], k);
            write_byte(vecs[v].wdata, ack);
            check($sformatf("v%0d_data_ack", v), ack, vecs[v].exp_ack);
            bus_stop();
            check($sformatf("v%0d_busy_stop", v), busy, 1'b0);
            check($sformatf("v%0d_wv_count", v), log_addr.size(), vecs[v].exp_wv ? 1 : 0);
            if (log_addr.size() > 0) begin
                check($sformatf("v%0d_wr_addr", v), log_addr[0], vecs[v].waddr);
                check($sformatf("v%0d_wr_data", v), log_data[0], vecs[v].wdata);
            end
            // Pointer set in one transaction, read in the next.
            bus_start();
            write_byte(8'h78, k);
            write_byte(vecs[v].raddr[15:8], k);
            write_byte(vecs[v].raddr[7:0], k);
            bus_stop();
            bus_start();
            write_byte(8'h79, k);
            read_byte(d, 1'b0);
            check($sformatf("v%0d_nack_release", v), sda_t, 1'b1);
            bus_stop();
            check($sformatf("v%0d_rdata", v), d, vecs[v].rdata);
        end

        // Burst write 0x4300..0x4302, then burst read with ACK,ACK,NACK.
        clear_log();
        bus_start();
        write_byte(8'h78, k);
        write_byte(8'h43, k);
        write_byte(8'h00, k);
        write_byte(8'h30, k);
        write_byte(8'h31, k);
        write_byte(8'h32, ack);
        check("burst_last_ack", ack, 1'b1);
        bus_stop();
        check("burst_wv_count", log_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < log_addr.size()) begin
                check($sformatf("burst_addr%0d", i), log_addr[i], 16'h4300 + 16'(i));
                check($sformatf("burst_data%0d", i), log_data[i], 8'h30 + 8'(i));
            end
        end
        point_read(16'h4300);
        read_byte(d, 1'b1);
        read_byte(d1, 1'b1);
        read_byte(d2, 1'b0);
        check("burst_nack_release", sda_t, 1'b1);
        bus_stop();
        check("burst_rd0", d,  8'h30);
        check("burst_rd1", d1, 8'h31);
        check("burst_rd2", d2, 8'h32);

        // Chip ID: fixed values and write protection when enabled,
        // ordinary memory otherwise.
        do_write(16'h300B, 8'h22, k);
        point_read(16'h300A);
        read_byte(d, 1'b1);
        read_byte(d1, 1'b0);
        bus_stop();
        check("chip_rd_h", d,  CHIP ? 8'h56 : 8'h11);
        check("chip_rd_l", d1, CHIP ? 8'h40 : 8'h22);
        clear_log();
        do_write(16'h300A, 8'hFF, ack);
        check("chip_wr_ack", ack, 1'b1);
        check("chip_wr_wv", log_addr.size(), CHIP ? 0 : 1);
        point_read(16'h300A);
        read_byte(d, 1'b0);
        bus_stop();
        check("chip_reread", d, CHIP ? 8'h56 : 8'hFF);

        // One-cycle SCL glitches while SCL is high must be ignored.
        clear_log();
        bus_start();
        write_byte(8'h78, ack, 3);
        check("glitch_dev_ack", ack, 1'b1);
        write_byte(8'h00, k);
        write_byte(8'h10, k);
        write_byte(8'h96, ack, 0);
        check("glitch_data_ack", ack, 1'b1);
        bus_stop();
        check("glitch_wv_count", log_addr.size(), 1);
        if (log_addr.size() > 0) begin
            check("glitch_wr_addr", log_addr[0], 16'h0010);
            check("glitch_wr_data", log_data[0], 8'h96);
        end

        // Repeated START after four data bits: partial byte is dropped.
        do_write(16'h0020, 8'h77, k);
        clear_log();
        bus_start();
        write_byte(8'h78, k);
        write_byte(8'h00, k);
        write_byte(8'h20, k);
        write_bit(1'b1, 1'b0);
        write_bit(1'b0, 1'b0);
        write_bit(1'b1, 1'b0);
        write_bit(1'b1, 1'b0);
        bus_start();
        write_byte(8'h79, ack);
        check("rstart_dev_ack", ack, 1'b1);
        read_byte(d, 1'b0);
        bus_stop();
        check("rstart_rdata", d, 8'h77);
        check("rstart_wv_count", log_addr.size(), 0);

        // Reset while the slave drives a '0' read bit (0x77 MSB).
        point_read(16'h0020);
        check("rd_bit_drive", sda_t, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_sda_t", sda_t, 1'b1);
        check("rst_mid_busy",  busy,  1'b0);
        check("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        // Pointer returns to 0; register file keeps its contents.
        bus_start();
        write_byte(8'h79, ack);
        check("post_rst_ack", ack, 1'b1);
        read_byte(d, 1'b0);
        bus_stop();
        check("post_rst_ptr0", d, 8'h30);
        point_read(16'h0020);
        read_byte(d, 1'b0);
        bus_stop();
        check("post_rst_mem_kept", d, 8'h77);

        // Pointer wraps 0xFFFF -> 0x0000 after a write.
        do_write(16'hFFFF, 8'hE7, k);
        bus_start();
        write_byte(8'h79, k);
        read_byte(d, 1'b0);
        bus_stop();
        check("ptr_wrap", d, 8'h30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
